cfuop_sa_gen2: RTL
==================

CFUOP_SA_GEN2 -- requirements
Module: cfuop_sa_gen2

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10: word-address width of buffers A, B and C.
REQ-002 SHALL have parameter LANES, default 4: number of 32-bit accumulator lanes per C word; C word width = 32*LANES.
REQ-003 SHALL have parameter DIM_BITS, default 8: width of the K, M and N configuration registers.
REQ-004 SHALL have ports (one clock; reset asynchronous, active-high):
  clk  in  1  clock.
  reset  in  1  asynchronous reset, active-high.
  cmd_valid  in  1  command present.
  cmd_ready  out  1  command accepted this cycle.
  cmd_payload_function_id  in  10  function7 = bits [9:3].
  cmd_payload_inputs_0  in  32  write data, or C lane index.
  cmd_payload_inputs_1  in  32  buffer address, or config index.
  rsp_valid  out  1  response present.
  rsp_ready  in  1  response consumed.
  rsp_payload_outputs_0  out  32  response data.
  eng_start  out  1  one-cycle GEMM start pulse.
  eng_busy  in  1  engine running.
  eng_done  in  1  one-cycle completion pulse.
  eng_k, eng_m, eng_n  out  DIM_BITS each  configuration values.
  eng_offset  out  9  input offset.
  eng_a_addr, eng_b_addr  in  ADDR_BITS each  engine read addresses.
  eng_a_dout, eng_b_dout  out  32 each  buffer read data, one cycle after the address.
  eng_c_we  in  1  C write enable.
  eng_c_addr  in  ADDR_BITS  C write address.
  eng_c_din  in  32*LANES  C write data.

Function
REQ-005 SHALL decode function7 as follows:
  - f7[0]=1: compute.
  - otherwise f7[6]: 1 = write, 0 = read.
  - f7[5:4] selects the target: 0 config, 1 A, 2 B, 3 C.
REQ-006 SHALL implement FSM states IDLE, RD_WAIT, RSP, COMPUTE.
REQ-007 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid&cmd_ready.
REQ-008 On an accepted write: SHALL commit the buffer or config write in the accept cycle, then go to RSP with payload 0.
REQ-009 On an accepted buffer read: SHALL issue the BRAM read in the accept cycle, go to RD_WAIT, capture data next cycle, then go to RSP (rsp_valid two cycles after accept).
REQ-010 On an accepted config read: SHALL go directly to RSP (rsp_valid one cycle after accept).
REQ-011 In RSP: SHALL hold rsp_valid=1 and a stable payload until rsp_ready, then return to IDLE.
REQ-012 Config indices (inputs_1[2:0]):
  - 0 K, 1 M, 2 N, 3 OFFSET: read/write.
  - 4 STATUS = {30'b0, spurious_done, busy}: read-only.
  - 5 CYCLES: read-only.
  - 6, 7: read as 0; writes ignored.
REQ-013 Writes to a config register SHALL truncate the written value to the register width.
REQ-014 C read SHALL return lane inputs_0[$clog2(LANES)-1:0]; lane 0 = bits [31:0].
REQ-015 A lane index >= LANES SHALL return 0.
REQ-016 Buffer addresses SHALL be inputs_1[ADDR_BITS-1:0]; upper bits are ignored.
REQ-017 On an accepted compute: SHALL pulse eng_start the cycle after accept, clear CYCLES, and enter COMPUTE.
REQ-018 In COMPUTE:
  - CYCLES increments every cycle, saturating at 0xFFFFFFFF.
  - Buffer ports are muxed to the engine.
  - On eng_done, go to RSP with payload = final CYCLES.
REQ-019 eng_done in any state other than COMPUTE SHALL set sticky spurious_done.
REQ-020 spurious_done SHALL be cleared only by a write to config index 4.
REQ-021 eng_c_we outside COMPUTE SHALL be ignored.
REQ-022 If cmd_valid and eng_done occur in the same cycle, eng_done SHALL take priority; the command waits because cmd_ready is low.

Reset
REQ-023 reset SHALL asynchronously force:
  - state IDLE;
  - cmd_ready=0, rsp_valid=0, rsp_payload_outputs_0=0, eng_start=0;
  - K, M, N, OFFSET, CYCLES, spurious_done = 0.
REQ-024 cmd_ready SHALL rise in the first cycle after reset deasserts.
REQ-025 Buffer contents SHALL NOT be cleared by reset.
REQ-026 Reset asserted during COMPUTE SHALL abandon the operation with no response.

Structure
REQ-027 The function7 field positions, target codes, config indices and FSM state encoding SHALL live in the shared package cfu_sa_pkg.
REQ-028 Buffers A, B and C SHALL each be an instance of sub-module global_buffer_bram (single port, 1-cycle read).

Verification
REQ-029 Reset, then write K=16 and read K -> rsp payload 16, rsp_valid one cycle after accept.
REQ-030 Write A[5]=0xDEADBEEF, read A[5] with rsp_ready low for 3 cycles -> rsp_valid held, payload stable at 0xDEADBEEF, cmd_ready low until consumed.
REQ-031 Engine writes C[2] = {0x4, 0x3, 0x2, 0x1} (LANES=4); read lanes 0..3 -> 0x1, 0x2, 0x3, 0x4; lane index 7 -> 0.
REQ-032 Compute, eng_done 20 cycles after eng_start -> response CYCLES=21; STATUS busy=1 while in COMPUTE.
REQ-033 eng_done pulsed in IDLE -> STATUS reads 0x2; write to index 4 -> STATUS reads 0x0.
REQ-034 Reset asserted mid-COMPUTE -> no rsp_valid; K reads 0; A contents preserved.

Source files
------------

// File: rtl/cfu_sa_pkg.sv
// Shared encodings for the systolic-array CFU front end: function7 fields,
// buffer target codes, config register indices and controller state encoding.
package cfu_sa_pkg;

    localparam int F7_COMPUTE_BIT = 0;
    localparam int F7_WRITE_BIT   = 6;
    localparam int F7_TGT_LSB     = 4;

    typedef enum logic [1:0] {
        TGT_CFG = 2'd0,
        TGT_A   = 2'd1,
        TGT_B   = 2'd2,
        TGT_C   = 2'd3
    } target_t;

    localparam logic [2:0] CFG_K      = 3'd0;
    localparam logic [2:0] CFG_M      = 3'd1;
    localparam logic [2:0] CFG_N      = 3'd2;
    localparam logic [2:0] CFG_OFFSET = 3'd3;
    localparam logic [2:0] CFG_STATUS = 3'd4;
    localparam logic [2:0] CFG_CYCLES = 3'd5;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RSP     = 2'd2;
    localparam logic [1:0] ST_COMPUTE = 2'd3;

endpackage

// File: rtl/global_buffer_bram.sv
// Single-port block RAM with registered read (read-first); contents survive reset.
module global_buffer_bram #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout
);

    logic [DATA_BITS-1:0] mem [0:(1<<ADDR_BITS)-1];
    logic [DATA_BITS-1:0] dout_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout_reg <= mem[addr];
    end

    assign dout = dout_reg;

endmodule

// File: rtl/cfuop_sa_gen2.sv
// CFU command front end for a GEMM engine: buffer/config access over the
// cmd/rsp handshake, compute launch, cycle counting and spurious-done tracking.
module cfuop_sa_gen2
    import cfu_sa_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LANES     = 4,
    parameter int DIM_BITS  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [9:0]             cmd_payload_function_id,
    input  logic [31:0]            cmd_payload_inputs_0,
    input  logic [31:0]            cmd_payload_inputs_1,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_payload_outputs_0,
    output logic                   eng_start,
    input  logic                   eng_busy,
    input  logic                   eng_done,
    output logic [DIM_BITS-1:0]    eng_k,
    output logic [DIM_BITS-1:0]    eng_m,
    output logic [DIM_BITS-1:0]    eng_n,
    output logic [8:0]             eng_offset,
    input  logic [ADDR_BITS-1:0]   eng_a_addr,
    input  logic [ADDR_BITS-1:0]   eng_b_addr,
    output logic [31:0]            eng_a_dout,
    output logic [31:0]            eng_b_dout,
    input  logic                   eng_c_we,
    input  logic [ADDR_BITS-1:0]   eng_c_addr,
    input  logic [32*LANES-1:0]    eng_c_din
);

    localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int C_BITS    = 32 * LANES;

    logic [1:0]           state_reg, state_next;
    logic                 ready_reg;
    logic                 start_reg;
    logic [31:0]          payload_reg;
    logic [DIM_BITS-1:0]  k_reg, m_reg, n_reg;
    logic [8:0]           offset_reg;
    logic [31:0]          cycles_reg;
    logic                 spurious_reg;
    target_t              rd_target_reg;
    logic [LANE_BITS-1:0] lane_reg;
    logic                 lane_ok_reg;

    logic [6:0]           f7;
    target_t              target;
    logic                 is_compute, is_write, accept, in_compute, busy;
    logic [2:0]           cfg_idx;
    logic [ADDR_BITS-1:0] buf_addr;
    logic [31:0]          cfg_rdata, rd_data, cycles_inc;

    logic                 a_we, b_we, c_we;
    logic [ADDR_BITS-1:0] a_addr, b_addr, c_addr;
    logic [31:0]          a_dout, b_dout;
    logic [C_BITS-1:0]    c_dout;
    logic [31:0]          c_lanes [LANES];

    logic unused_bits;
    assign unused_bits = ^{cmd_payload_function_id[2:0], cmd_payload_inputs_1};

    assign f7         = cmd_payload_function_id[9:3];
    assign is_compute = f7[F7_COMPUTE_BIT];
    assign is_write   = f7[F7_WRITE_BIT];
    assign target     = target_t'(f7[F7_TGT_LSB +: 2]);
    assign cfg_idx    = cmd_payload_inputs_1[2:0];
    assign buf_addr   = cmd_payload_inputs_1[ADDR_BITS-1:0];
    assign in_compute = (state_reg == ST_COMPUTE);
    assign busy       = in_compute | eng_busy;

    // A completion pulse owns the cycle: hold off commands so it is never lost.
    assign cmd_ready  = ready_reg & ~eng_done;
    assign accept     = cmd_valid & cmd_ready;
    assign cycles_inc = (cycles_reg == 32'hFFFF_FFFF) ? cycles_reg : cycles_reg + 32'd1;

    // The engine owns the buffer ports only while computing.
    assign a_we   = accept & ~is_compute & is_write & (target == TGT_A);
    assign b_we   = accept & ~is_compute & is_write & (target == TGT_B);
    assign c_we   = in_compute & eng_c_we;
    assign a_addr = in_compute ? eng_a_addr : buf_addr;
    assign b_addr = in_compute ? eng_b_addr : buf_addr;
    assign c_addr = in_compute ? eng_c_addr : buf_addr;

    global_buffer_bram #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(32)) u_buf_a (
        .clk(clk), .we(a_we), .addr(a_addr), .din(cmd_payload_inputs_0), .dout(a_dout)
    );
    global_buffer_bram #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(32)) u_buf_b (
        .clk(clk), .we(b_we), .addr(b_addr), .din(cmd_payload_inputs_0), .dout(b_dout)
    );
    // Host writes to C are dropped; C is written by the engine only.
    global_buffer_bram #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(C_BITS)) u_buf_c (
        .clk(clk), .we(c_we), .addr(c_addr), .din(eng_c_din), .dout(c_dout)
    );

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign c_lanes[gi] = c_dout[gi*32 +: 32];
        end
    endgenerate

    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_idx)
            CFG_K:      cfg_rdata = 32'(k_reg);
            CFG_M:      cfg_rdata = 32'(m_reg);
            CFG_N:      cfg_rdata = 32'(n_reg);
            CFG_OFFSET: cfg_rdata = 32'(offset_reg);
            CFG_STATUS: cfg_rdata = {30'd0, spurious_reg, busy};
            CFG_CYCLES: cfg_rdata = cycles_reg;
            default:    cfg_rdata = 32'd0;
        endcase
    end

    always_comb begin
        rd_data = 32'd0;
        case (rd_target_reg)
            TGT_A:   rd_data = a_dout;
            TGT_B:   rd_data = b_dout;
            TGT_C:   rd_data = lane_ok_reg ? c_lanes[lane_reg] : 32'd0;
            default: rd_data = 32'd0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (is_compute)                           state_next = ST_COMPUTE;
                    else if (is_write || target == TGT_CFG)   state_next = ST_RSP;
                    else                                      state_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: state_next = ST_RSP;
            ST_RSP:     if (rsp_ready) state_next = ST_IDLE;
            ST_COMPUTE: if (eng_done)  state_next = ST_RSP;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            ready_reg     <= 1'b0;
            start_reg     <= 1'b0;
            payload_reg   <= 32'd0;
            k_reg         <= '0;
            m_reg         <= '0;
            n_reg         <= '0;
            offset_reg    <= '0;
            cycles_reg    <= 32'd0;
            spurious_reg  <= 1'b0;
            rd_target_reg <= TGT_CFG;
            lane_reg      <= '0;
            lane_ok_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == ST_IDLE);
            start_reg <= accept & is_compute;
            if (eng_done && !in_compute) begin
                spurious_reg <= 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_compute) begin
                            cycles_reg <= 32'd0;
                        end else if (is_write) begin
                            payload_reg <= 32'd0;
                            if (target == TGT_CFG) begin
                                case (cfg_idx)
                                    CFG_K:      k_reg        <= cmd_payload_inputs_0[DIM_BITS-1:0];
                                    CFG_M:      m_reg        <= cmd_payload_inputs_0[DIM_BITS-1:0];
                                    CFG_N:      n_reg        <= cmd_payload_inputs_0[DIM_BITS-1:0];
                                    CFG_OFFSET: offset_reg   <= cmd_payload_inputs_0[8:0];
                                    CFG_STATUS: spurious_reg <= 1'b0;
                                    default: ;
                                endcase
                            end
                        end else if (target == TGT_CFG) begin
                            payload_reg <= cfg_rdata;
                        end else begin
                            rd_target_reg <= target;
                            lane_reg      <= cmd_payload_inputs_0[LANE_BITS-1:0];
                            lane_ok_reg   <= (cmd_payload_inputs_0 < 32'(LANES));
                        end
                    end
                end
                ST_RD_WAIT: payload_reg <= rd_data;
                ST_COMPUTE: begin
                    cycles_reg <= cycles_inc;
                    if (eng_done) begin
                        payload_reg <= cycles_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid             = (state_reg == ST_RSP);
    assign rsp_payload_outputs_0 = payload_reg;
    assign eng_start             = start_reg;
    assign eng_k                 = k_reg;
    assign eng_m                 = m_reg;
    assign eng_n                 = n_reg;
    assign eng_offset            = offset_reg;
    assign eng_a_dout            = a_dout;
    assign eng_b_dout            = b_dout;

endmodule
